// File: rtl/psg_pkg.sv
// Shared definitions for the PSG write port: byte field positions, register
// file layout, and the latch/data decode used when a byte reaches the sound domain.
`timescale 1ns/1ps
package psg_pkg;

  localparam int LATCH_BIT = 7;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam int TYP_BIT   = 4;

  localparam logic [1:0] NOISE_CH  = 2'd3;
  localparam logic [3:0] ATTEN_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2
  } snd_state_e;

  typedef struct packed {
    logic [2:0][9:0] tone;
    logic [3:0][3:0] atten;
    logic [2:0]      noise_ctl;
    logic [1:0]      latch_ch;
    logic            latch_typ;
  } psg_regs_t;

  localparam psg_regs_t REGS_RESET = '{
    tone:      '0,
    atten:     {4{ATTEN_OFF}},
    noise_ctl: 3'b000,
    latch_ch:  2'd0,
    latch_typ: 1'b0
  };

  // Channel/type a byte acts on: a latch byte names its own target, a data
  // byte reuses whatever the last latch byte selected.
  function automatic logic [2:0] psg_target(input psg_regs_t cur, input logic [7:0] b);
    if (b[LATCH_BIT])
      return {b[CH_MSB:CH_LSB], b[TYP_BIT]};
    else
      return {cur.latch_ch, cur.latch_typ};
  endfunction

  function automatic logic psg_hits_noise(input psg_regs_t cur, input logic [7:0] b);
    return psg_target(cur, b) == {NOISE_CH, 1'b0};
  endfunction

  function automatic psg_regs_t psg_decode(input psg_regs_t cur, input logic [7:0] b);
    psg_regs_t  nxt;
    logic [1:0] ch;
    logic       typ;
    nxt        = cur;
    {ch, typ}  = psg_target(cur, b);
    if (b[LATCH_BIT]) begin
      nxt.latch_ch  = ch;
      nxt.latch_typ = typ;
    end
    if (typ)
      nxt.atten[ch] = b[3:0];
    else if (ch == NOISE_CH)
      nxt.noise_ctl = b[2:0];
    else if (b[LATCH_BIT])
      nxt.tone[ch][3:0] = b[3:0];
    else
      nxt.tone[ch][9:4] = b[5:0];
    return nxt;
  endfunction

endpackage

// File: rtl/psg_write_port_if.sv
// CPU-side byte write bus of the PSG: chip select, write enable, data and the
// READY handshake back to the CPU.
`timescale 1ns/1ps
interface psg_write_port_if;

  logic       cs;
  logic       we;
  logic [7:0] din;
  logic       ready;

  modport master (output cs, output we, output din, input ready);
  modport slave  (input cs, input we, input din, output ready);

endinterface

// File: rtl/psg_write_port_sync2.sv
// Two-flop single-bit synchronizer with asynchronous reset, used for the
// req/ack toggles crossing between cpuclk and sndclk.
`timescale 1ns/1ps
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/psg_write_port.sv
// PSG register-write responder: captures CPU bytes with a READY handshake,
// moves them into the sound clock domain by toggle handshake and decodes them.
`timescale 1ns/1ps
module psg_write_port
  import psg_pkg::*;
#(
  parameter int WAIT_CYCLES = 32
) (
  input  logic             cpuclk,
  input  logic             sndclk,
  input  logic             reset,
  psg_write_port_if.slave  bus,
  output logic [9:0]       tone0,
  output logic [9:0]       tone1,
  output logic [9:0]       tone2,
  output logic [3:0]       atten0,
  output logic [3:0]       atten1,
  output logic [3:0]       atten2,
  output logic [3:0]       atten3,
  output logic [2:0]       noise_ctl,
  output logic             noise_rst
);

  localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

  logic [7:0] hold_q, hold_d;
  logic       req_q, req_d;
  logic       ready_q, ready_d;
  logic       ack_sync;
  logic       accept;

  snd_state_e state_q, state_d;
  logic       local_q, local_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       noise_rst_q, noise_rst_d;
  psg_regs_t  regs_q, regs_d;
  logic       req_sync;

  assign accept = bus.cs & bus.we & ready_q;

  // The hold register only changes while ready is high, so it is stable for
  // the whole time the sound domain may be reading it.
  always_comb begin
    hold_d  = hold_q;
    req_d   = req_q;
    ready_d = ready_q;
    if (accept) begin
      hold_d  = bus.din;
      req_d   = ~req_q;
      ready_d = 1'b0;
    end else begin
      ready_d = (ack_sync == req_q);
    end
  end

  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      hold_q  <= 8'h00;
      req_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      hold_q  <= hold_d;
      req_q   <= req_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready = ready_q;

  sync2 u_req_sync (
    .clk   (sndclk),
    .reset (reset),
    .d     (req_q),
    .q     (req_sync)
  );

  sync2 u_ack_sync (
    .clk   (cpuclk),
    .reset (reset),
    .d     (ack_q),
    .q     (ack_sync)
  );

  always_comb begin
    state_d     = state_q;
    local_d     = local_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    regs_d      = regs_q;
    noise_rst_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_sync != local_q)
          state_d = ST_APPLY;
      end
      ST_APPLY: begin
        regs_d      = psg_decode(regs_q, hold_q);
        noise_rst_d = psg_hits_noise(regs_q, hold_q);
        local_d     = req_sync;
        cnt_d       = CNT_LOAD;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Acknowledge only after the modelled chip write time has elapsed.
        if (cnt_q == 8'd0) begin
          ack_d   = ~ack_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sndclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      local_q     <= 1'b0;
      cnt_q       <= 8'd0;
      ack_q       <= 1'b0;
      regs_q      <= REGS_RESET;
      noise_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      local_q     <= local_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      regs_q      <= regs_d;
      noise_rst_q <= noise_rst_d;
    end
  end

  assign tone0     = regs_q.tone[0];
  assign tone1     = regs_q.tone[1];
  assign tone2     = regs_q.tone[2];
  assign atten0    = regs_q.atten[0];
  assign atten1    = regs_q.atten[1];
  assign atten2    = regs_q.atten[2];
  assign atten3    = regs_q.atten[3];
  assign noise_ctl = regs_q.noise_ctl;
  assign noise_rst = noise_rst_q;

endmodule

// File: tb/tb_psg_write_port.sv
// Self-checking bench for psg_write_port: directed vector table, busy and
// reset sequences, then random bytes under two clock ratios against a model.
`timescale 1ns/1ps
module tb_psg_write_port;

  localparam int WAIT_CYCLES = 32;

  typedef struct {
    logic [7:0]  din;
    logic [29:0] tones;
    logic [15:0] attens;
    logic [2:0]  noise;
    int          pulses;
  } vec_t;

  logic    cpuclk = 1'b0;
  logic    sndclk = 1'b0;
  logic    reset;
  realtime cpu_half = 166.667;
  realtime snd_half = 312.5;

  always #(cpu_half) cpuclk = ~cpuclk;
  always #(snd_half) sndclk = ~sndclk;

  psg_write_port_if bus ();

  logic [9:0] tone0, tone1, tone2;
  logic [3:0] atten0, atten1, atten2, atten3;
  logic [2:0] noise_ctl;
  logic       noise_rst;

  psg_write_port #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .cpuclk    (cpuclk),
    .sndclk    (sndclk),
    .reset     (reset),
    .bus       (bus.slave),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .atten0    (atten0),
    .atten1    (atten1),
    .atten2    (atten2),
    .atten3    (atten3),
    .noise_ctl (noise_ctl),
    .noise_rst (noise_rst)
  );

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int snd_cycles = 0;
  int cap_snd = 0;

  int tone_m [3];
  int atten_m [4];
  int noise_m;
  int lch, ltyp;
  int exp_pulses = 0;

  vec_t vecs [6];

  // Each sndclk period that noise_rst is seen high counts once, so a stretched
  // pulse shows up as an extra count.
  always @(negedge sndclk) if (noise_rst === 1'b1) pulse_cnt++;
  always @(posedge sndclk) snd_cycles++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_file();
    return {15'b0, tone2, tone1, tone0, atten3, atten2, atten1, atten0, noise_ctl};
  endfunction

  function automatic logic [63:0] model_file();
    return {15'b0, 10'(tone_m[2]), 10'(tone_m[1]), 10'(tone_m[0]),
            4'(atten_m[3]), 4'(atten_m[2]), 4'(atten_m[1]), 4'(atten_m[0]),
            3'(noise_m)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) tone_m[i] = 0;
    for (int i = 0; i < 4; i++) atten_m[i] = 15;
    noise_m = 0;
    lch = 0;
    ltyp = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b[7]) begin
      lch  = int'(b[6:5]);
      ltyp = int'(b[4]);
    end
    if (ltyp == 1) begin
      atten_m[lch] = int'(b[3:0]);
    end else if (lch == 3) begin
      noise_m = int'(b[2:0]);
      exp_pulses++;
    end else if (b[7]) begin
      tone_m[lch] = (tone_m[lch] & 32'h3F0) | int'(b[3:0]);
    end else begin
      tone_m[lch] = (tone_m[lch] & 32'h00F) | (int'(b[5:0]) << 4);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 4000) begin
      @(negedge cpuclk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL %s_timeout: got ready=%b, expected 1", name, bus.ready);
    end
  endtask

  // Called on a cpuclk falling edge; drives one write and confirms READY drops.
  task automatic applyStimulus(input logic [7:0] b);
    wait_ready("pre_write");
    bus.cs  = 1'b1;
    bus.we  = 1'b1;
    bus.din = b;
    @(posedge cpuclk);
    cap_snd = snd_cycles;
    @(negedge cpuclk);
    bus.cs = 1'b0;
    bus.we = 1'b0;
    check("ready_drop", 64'(bus.ready), 64'd0);
    model_apply(b);
  endtask

  task automatic checkOutput(input string name);
    wait_ready(name);
    check({name, "_file"}, dut_file(), model_file());
    check({name, "_pulses"}, 64'(pulse_cnt), 64'(exp_pulses));
  endtask

  initial begin
    #20ms;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 20ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         low_cycles;

    vecs[0] = '{8'hA5, {10'h000, 10'h005, 10'h000}, {4'hF, 4'hF, 4'hF, 4'hF}, 3'b000, 0};
    vecs[1] = '{8'h3F, {10'h000, 10'h3F5, 10'h000}, {4'hF, 4'hF, 4'hF, 4'hF}, 3'b000, 0};
    vecs[2] = '{8'hDA, {10'h000, 10'h3F5, 10'h000}, {4'hF, 4'hA, 4'hF, 4'hF}, 3'b000, 0};
    vecs[3] = '{8'h03, {10'h000, 10'h3F5, 10'h000}, {4'hF, 4'h3, 4'hF, 4'hF}, 3'b000, 0};
    vecs[4] = '{8'hE5, {10'h000, 10'h3F5, 10'h000}, {4'hF, 4'h3, 4'hF, 4'hF}, 3'b101, 1};
    vecs[5] = '{8'h06, {10'h000, 10'h3F5, 10'h000}, {4'hF, 4'h3, 4'hF, 4'hF}, 3'b110, 2};

    bus.cs  = 1'b0;
    bus.we  = 1'b0;
    bus.din = 8'h00;
    reset   = 1'b1;
    model_reset();
    #1000;
    @(negedge cpuclk);
    reset = 1'b0;
    @(negedge cpuclk);
    check("reset_ready", 64'(bus.ready), 64'd1);
    check("reset_file", dut_file(), model_file());
    check("reset_noise_rst", 64'(noise_rst), 64'd0);

    $display("[TB] directed table, cpuclk 3 MHz / sndclk 1.6 MHz");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].din);
      wait_ready($sformatf("vec%0d", i));
      check($sformatf("vec%0d_file", i), dut_file(),
            {15'b0, vecs[i].tones, vecs[i].attens, vecs[i].noise});
      check($sformatf("vec%0d_pulses", i), 64'(pulse_cnt), 64'(vecs[i].pulses));
    end

    $display("[TB] busy: second write while ready=0 must be dropped");
    applyStimulus(8'h9C);
    bus.cs  = 1'b1;
    bus.we  = 1'b1;
    bus.din = 8'h90;
    repeat (6) @(negedge cpuclk);
    check("busy_ready_low", 64'(bus.ready), 64'd0);
    bus.cs = 1'b0;
    bus.we = 1'b0;
    wait_ready("busy");
    low_cycles = snd_cycles - cap_snd;
    check("busy_wait_len", 64'(low_cycles >= WAIT_CYCLES), 64'd1);
    check("busy_file", dut_file(),
          {15'b0, 10'h000, 10'h3F5, 10'h000, 4'hF, 4'h3, 4'hF, 4'hC, 3'b110});
    checkOutput("busy_model");

    $display("[TB] reset in the middle of the wait phase");
    applyStimulus(8'hB0);
    repeat (10) @(posedge sndclk);
    #5;
    check("rst_midwait_ready", 64'(bus.ready), 64'd0);
    check("rst_applied_atten1", 64'(atten1), 64'h0);
    reset = 1'b1;
    #20;
    model_reset();
    check("rst_active_file", dut_file(), model_file());
    check("rst_active_ready", 64'(bus.ready), 64'd1);
    @(negedge cpuclk);
    reset = 1'b0;
    @(negedge cpuclk);
    check("rst_release_ready", 64'(bus.ready), 64'd1);
    repeat (80) @(negedge sndclk);
    @(negedge cpuclk);
    check("rst_settled_file", dut_file(), model_file());
    check("rst_settled_ready", 64'(bus.ready), 64'd1);
    check("rst_settled_pulses", 64'(pulse_cnt), 64'(exp_pulses));

    $display("[TB] random bytes, sndclk faster than cpuclk");
    snd_half = 50.0;
    repeat (4) @(negedge cpuclk);
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b);
      checkOutput($sformatf("fast%0d", i));
    end

    $display("[TB] random bytes, sndclk slower than cpuclk");
    snd_half = 500.0;
    repeat (4) @(negedge cpuclk);
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b);
      checkOutput($sformatf("slow%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
